// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: datapath defaults and ALU operation encodings.
package mips_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RADDR_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SRL = 3'b011,
        ALU_OR  = 3'b100,
        ALU_AND = 3'b101,
        ALU_SLT = 3'b110,
        ALU_BNE = 3'b111
    } aluop_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, bypass-side and ALU-side signals of the ID/EX stage, bundled with
// master (surrounding pipeline) and slave (the stage itself) modports.
interface id_ex_stage_if #(
    parameter int WIDTH = mips_pkg::WIDTH_DEF,
    parameter int RADDR = mips_pkg::RADDR_DEF
);
    // Handshake: there is no valid/ready pair; stall asks IF/ID to hold the
    // current decode, and flush squashes it. Both act on the next rising clk.
    logic             flush;
    logic [WIDTH-1:0] d_rs_data;
    logic [WIDTH-1:0] d_rt_data;
    logic [WIDTH-1:0] d_imm;
    logic [RADDR-1:0] d_rs;
    logic [RADDR-1:0] d_rt;
    logic [RADDR-1:0] d_rd;
    logic [4:0]       d_shamt;
    logic [2:0]       d_aluop;
    logic             d_alusrc;
    logic             d_regdst;
    logic             d_regwrite;
    logic             d_memread;
    logic             d_memwrite;
    logic             d_memtoreg;
    logic             d_branch;
    logic             xm_regwrite;
    logic [RADDR-1:0] xm_rd;
    logic [WIDTH-1:0] xm_result;
    logic             mw_regwrite;
    logic [RADDR-1:0] mw_rd;
    logic [WIDTH-1:0] mw_result;
    logic             stall;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] store_data;
    logic [2:0]       ALUop;
    logic [4:0]       shamt;
    logic [RADDR-1:0] e_dest;
    logic             e_regwrite;
    logic             e_memread;
    logic             e_memwrite;
    logic             e_memtoreg;
    logic             e_branch;

    modport slave (
        input  flush, d_rs_data, d_rt_data, d_imm, d_rs, d_rt, d_rd, d_shamt, d_aluop,
               d_alusrc, d_regdst, d_regwrite, d_memread, d_memwrite, d_memtoreg, d_branch,
               xm_regwrite, xm_rd, xm_result, mw_regwrite, mw_rd, mw_result,
        output stall, operand1, operand2, store_data, ALUop, shamt, e_dest,
               e_regwrite, e_memread, e_memwrite, e_memtoreg, e_branch
    );

    modport master (
        output flush, d_rs_data, d_rt_data, d_imm, d_rs, d_rt, d_rd, d_shamt, d_aluop,
               d_alusrc, d_regdst, d_regwrite, d_memread, d_memwrite, d_memtoreg, d_branch,
               xm_regwrite, xm_rd, xm_result, mw_regwrite, mw_rd, mw_result,
        input  stall, operand1, operand2, store_data, ALUop, shamt, e_dest,
               e_regwrite, e_memread, e_memwrite, e_memtoreg, e_branch
    );

endinterface

// File: rtl/forward_unit.sv
// Operand bypass select for one source register: EX/MEM beats MEM/WB beats the
// register-file value; register 0 is never bypassed.
module forward_unit #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] reg_addr_i,
    input  logic [WIDTH-1:0] reg_data_i,
    input  logic             xm_regwrite_i,
    input  logic [RADDR-1:0] xm_rd_i,
    input  logic [WIDTH-1:0] xm_result_i,
    input  logic             mw_regwrite_i,
    input  logic [RADDR-1:0] mw_rd_i,
    input  logic [WIDTH-1:0] mw_result_i,
    output logic [WIDTH-1:0] data_o
);

    logic xm_hit;
    logic mw_hit;

    assign xm_hit = xm_regwrite_i && (xm_rd_i != '0) && (xm_rd_i == reg_addr_i);
    assign mw_hit = mw_regwrite_i && (mw_rd_i != '0) && (mw_rd_i == reg_addr_i);

    always_comb begin
        data_o = reg_data_i;
        if (xm_hit) begin
            data_o = xm_result_i;
        end else if (mw_hit) begin
            data_o = mw_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use stall and branch flush.
// Define HAZARD_CNT_EN to add saturating stall_cnt/flush_cnt event counters.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_stage_if.slave bus
`ifdef HAZARD_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] dest;
        logic [4:0]       shamt;
        logic [2:0]       aluop;
        logic             alusrc;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             branch;
    } ex_fields_t;

    ex_fields_t       ex_q;
    ex_fields_t       ex_d;
    logic             hazard;
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // A load in this stage whose destination feeds the decode instruction cannot be bypassed yet.
    assign hazard = ex_q.memread && (ex_q.dest != '0) &&
                    ((ex_q.dest == bus.d_rs) || (ex_q.dest == bus.d_rt));
    assign bus.stall = hazard && !bus.flush;

    always_comb begin
        ex_d = '0;
        if (!bus.flush && !hazard) begin
            ex_d.rs_data  = bus.d_rs_data;
            ex_d.rt_data  = bus.d_rt_data;
            ex_d.imm      = bus.d_imm;
            ex_d.rs       = bus.d_rs;
            ex_d.rt       = bus.d_rt;
            ex_d.dest     = bus.d_regdst ? bus.d_rd : bus.d_rt;
            ex_d.shamt    = bus.d_shamt;
            ex_d.aluop    = bus.d_aluop;
            ex_d.alusrc   = bus.d_alusrc;
            ex_d.regwrite = bus.d_regwrite;
            ex_d.memread  = bus.d_memread;
            ex_d.memwrite = bus.d_memwrite;
            ex_d.memtoreg = bus.d_memtoreg;
            ex_d.branch   = bus.d_branch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
        .reg_addr_i    (ex_q.rs),
        .reg_data_i    (ex_q.rs_data),
        .xm_regwrite_i (bus.xm_regwrite),
        .xm_rd_i       (bus.xm_rd),
        .xm_result_i   (bus.xm_result),
        .mw_regwrite_i (bus.mw_regwrite),
        .mw_rd_i       (bus.mw_rd),
        .mw_result_i   (bus.mw_result),
        .data_o        (fwd_rs)
    );

    forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
        .reg_addr_i    (ex_q.rt),
        .reg_data_i    (ex_q.rt_data),
        .xm_regwrite_i (bus.xm_regwrite),
        .xm_rd_i       (bus.xm_rd),
        .xm_result_i   (bus.xm_result),
        .mw_regwrite_i (bus.mw_regwrite),
        .mw_rd_i       (bus.mw_rd),
        .mw_result_i   (bus.mw_result),
        .data_o        (fwd_rt)
    );

    assign bus.operand1   = fwd_rs;
    assign bus.operand2   = ex_q.alusrc ? ex_q.imm : fwd_rt;
    assign bus.store_data = fwd_rt;
    assign bus.ALUop      = ex_q.aluop;
    assign bus.shamt      = ex_q.shamt;
    assign bus.e_dest     = ex_q.dest;
    assign bus.e_regwrite = ex_q.regwrite;
    assign bus.e_memread  = ex_q.memread;
    assign bus.e_memwrite = ex_q.memwrite;
    assign bus.e_memtoreg = ex_q.memtoreg;
    assign bus.e_branch   = ex_q.branch;

`ifdef HAZARD_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (bus.flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass priority, register zero, load-use stall and flush.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if bus ();

`ifdef HAZARD_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    id_ex_stage dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef HAZARD_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_fwd();
        bus.xm_regwrite = 1'b0;
        bus.xm_rd       = '0;
        bus.xm_result   = '0;
        bus.mw_regwrite = 1'b0;
        bus.mw_rd       = '0;
        bus.mw_result   = '0;
    endtask

    task automatic clear_decode();
        bus.flush      = 1'b0;
        bus.d_rs_data  = '0;
        bus.d_rt_data  = '0;
        bus.d_imm      = '0;
        bus.d_rs       = '0;
        bus.d_rt       = '0;
        bus.d_rd       = '0;
        bus.d_shamt    = '0;
        bus.d_aluop    = ALU_ADD;
        bus.d_alusrc   = 1'b0;
        bus.d_regdst   = 1'b0;
        bus.d_regwrite = 1'b0;
        bus.d_memread  = 1'b0;
        bus.d_memwrite = 1'b0;
        bus.d_memtoreg = 1'b0;
        bus.d_branch   = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rs_data, input logic [31:0] rt_data,
                           input logic [2:0] op);
        clear_decode();
        bus.d_rs       = rs;
        bus.d_rt       = rt;
        bus.d_rd       = rd;
        bus.d_rs_data  = rs_data;
        bus.d_rt_data  = rt_data;
        bus.d_aluop    = op;
        bus.d_regdst   = 1'b1;
        bus.d_regwrite = 1'b1;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        clear_decode();
        bus.d_rs       = rs;
        bus.d_rt       = rt;
        bus.d_rs_data  = 32'h100;
        bus.d_imm      = imm;
        bus.d_alusrc   = 1'b1;
        bus.d_regwrite = 1'b1;
        bus.d_memread  = 1'b1;
        bus.d_memtoreg = 1'b1;
    endtask

    initial begin
        clear_decode();
        clear_fwd();
        reset = 1'b1;
        #3;
        check("rst_aluop", bus.ALUop, 32'h0);
        check("rst_regwrite", bus.e_regwrite, 32'h0);
        check("rst_stall", bus.stall, 32'h0);
        check("rst_op1", bus.operand1, 32'h0);
        tick();
        reset = 1'b0;

        // Plain capture, then bypass on rs and rt.
        set_alu(5'd5, 5'd6, 5'd7, 32'hAAAA, 32'hBBBB, ALU_SUB);
        bus.d_shamt = 5'd3;
        tick();
        check("cap_dest", bus.e_dest, 32'd7);
        check("cap_aluop", bus.ALUop, 32'h1);
        check("cap_shamt", bus.shamt, 32'd3);
        check("cap_regwrite", bus.e_regwrite, 32'h1);
        check("cap_op1", bus.operand1, 32'hAAAA);
        check("cap_op2", bus.operand2, 32'hBBBB);
        bus.xm_regwrite = 1'b1;
        bus.xm_rd       = 5'd5;
        bus.xm_result   = 32'h1234;
        #1;
        check("xm_fwd_op1", bus.operand1, 32'h1234);
        bus.mw_regwrite = 1'b1;
        bus.mw_rd       = 5'd6;
        bus.mw_result   = 32'h5555;
        #1;
        check("mw_fwd_op2", bus.operand2, 32'h5555);

        // Reset during active traffic takes effect without a clock edge.
        reset = 1'b1;
        #1;
        check("midrst_regwrite", bus.e_regwrite, 32'h0);
        check("midrst_aluop", bus.ALUop, 32'h0);
        check("midrst_dest", bus.e_dest, 32'h0);
        check("midrst_stall", bus.stall, 32'h0);
        reset = 1'b0;
        clear_fwd();

        // EX/MEM beats MEM/WB on the same register.
        set_alu(5'd3, 5'd5, 5'd9, 32'h30, 32'h50, ALU_OR);
        tick();
        bus.xm_regwrite = 1'b1;
        bus.xm_rd       = 5'd5;
        bus.xm_result   = 32'h1111;
        bus.mw_regwrite = 1'b1;
        bus.mw_rd       = 5'd5;
        bus.mw_result   = 32'h2222;
        #1;
        check("prio_op2", bus.operand2, 32'h1111);
        check("prio_store", bus.store_data, 32'h1111);
        bus.xm_regwrite = 1'b0;
        #1;
        check("prio_mw_op2", bus.operand2, 32'h2222);
        clear_fwd();

        // Immediate operand; store_data still carries forwarded rt.
        set_alu(5'd3, 5'd5, 5'd9, 32'h30, 32'h50, ALU_ADD);
        bus.d_alusrc = 1'b1;
        bus.d_imm    = 32'h10;
        tick();
        check("imm_op2", bus.operand2, 32'h10);
        check("imm_store", bus.store_data, 32'h50);
        bus.mw_regwrite = 1'b1;
        bus.mw_rd       = 5'd5;
        bus.mw_result   = 32'h77;
        #1;
        check("imm_store_fwd", bus.store_data, 32'h77);
        check("imm_op2_hold", bus.operand2, 32'h10);
        clear_fwd();

        // Register zero is never bypassed.
        set_alu(5'd0, 5'd4, 5'd2, 32'h0, 32'h40, ALU_AND);
        tick();
        bus.xm_regwrite = 1'b1;
        bus.xm_rd       = 5'd0;
        bus.xm_result   = 32'hFFFF;
        bus.mw_regwrite = 1'b1;
        bus.mw_rd       = 5'd0;
        bus.mw_result   = 32'hEEEE;
        #1;
        check("r0_op1", bus.operand1, 32'h0);
        clear_fwd();

        // Load-use: one stall cycle, a bubble, then issue with MEM/WB bypass.
        set_lw(5'd1, 5'd8, 32'h4);
        tick();
        check("lw_memread", bus.e_memread, 32'h1);
        check("lw_dest", bus.e_dest, 32'd8);
        check("lw_op2", bus.operand2, 32'h4);
        set_alu(5'd9, 5'd8, 5'd10, 32'h90, 32'h0, ALU_ADD);
        #1;
        check("lu_stall", bus.stall, 32'h1);
        tick();
        check("lu_bubble_rw", bus.e_regwrite, 32'h0);
        check("lu_bubble_mr", bus.e_memread, 32'h0);
        check("lu_stall_end", bus.stall, 32'h0);
        tick();
        bus.mw_regwrite = 1'b1;
        bus.mw_rd       = 5'd8;
        bus.mw_result   = 32'hCAFE;
        #1;
        check("lu_issue_rw", bus.e_regwrite, 32'h1);
        check("lu_issue_dest", bus.e_dest, 32'd10);
        check("lu_issue_op1", bus.operand1, 32'h90);
        check("lu_issue_op2", bus.operand2, 32'hCAFE);
        clear_fwd();

        // Flush together with a hazard: no stall, bubble loaded.
        set_lw(5'd1, 5'd8, 32'h4);
        tick();
        set_alu(5'd8, 5'd3, 5'd11, 32'h0, 32'h0, ALU_SUB);
        bus.flush = 1'b1;
        #1;
        check("fh_stall", bus.stall, 32'h0);
        tick();
        bus.flush = 1'b0;
        check("fh_regwrite", bus.e_regwrite, 32'h0);
        check("fh_memread", bus.e_memread, 32'h0);
        check("fh_dest", bus.e_dest, 32'h0);

        // Flush of an ordinary instruction.
        set_alu(5'd2, 5'd3, 5'd12, 32'h0, 32'h0, ALU_SLT);
        bus.d_branch = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fl_aluop", bus.ALUop, 32'h0);
        check("fl_branch", bus.e_branch, 32'h0);
        check("fl_dest", bus.e_dest, 32'h0);

        // Reset asserted mid-stall drops stall at once.
        set_lw(5'd1, 5'd8, 32'h4);
        tick();
        set_alu(5'd8, 5'd3, 5'd11, 32'h0, 32'h0, ALU_ADD);
        #1;
        check("rs_stall_pre", bus.stall, 32'h1);
        reset = 1'b1;
        #1;
        check("rs_stall_post", bus.stall, 32'h0);
        check("rs_memread", bus.e_memread, 32'h0);
        tick();
        reset = 1'b0;

`ifdef HAZARD_CNT_EN
        check("cnt_rst_stall", stall_cnt, 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_lw(5'd1, 5'd8, 32'h4);
            tick();
            set_alu(5'd8, 5'd3, 5'd11, 32'h0, 32'h0, ALU_ADD);
            tick();
        end
        set_alu(5'd2, 5'd3, 5'd12, 32'h0, 32'h0, ALU_ADD);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("cnt_stall", stall_cnt, 32'd3);
        check("cnt_flush", flush_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly upstream of the ALU and drives its operand1, operand2, ALUop and shamt inputs.
- Contains the operand forwarding muxes, which source from EX/MEM and MEM/WB.
- Contains load-use hazard detection, which stalls IF/ID and inserts a bubble.
- Accepts a flush from branch resolution.

Parameters:
WIDTH, 32, datapath width
RADDR, 5, register-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  branch taken; squash the decode-stage instruction
d_rs_data  in  WIDTH  register-file rs value
d_rt_data  in  WIDTH  register-file rt value
d_imm  in  WIDTH  sign-extended immediate
d_rs, d_rt, d_rd  in  RADDR each  decode register addresses
d_shamt  in  5  shift amount
d_aluop  in  3  ALU operation code (encodings in package)
d_alusrc, d_regdst, d_regwrite, d_memread, d_memwrite, d_memtoreg, d_branch  in  1 each  decode controls
xm_regwrite  in  1  EX/MEM write enable
xm_rd  in  RADDR  EX/MEM destination
xm_result  in  WIDTH  EX/MEM ALU result
mw_regwrite  in  1  MEM/WB write enable
mw_rd  in  RADDR  MEM/WB destination
mw_result  in  WIDTH  MEM/WB writeback value
stall  out  1  hold PC and IF/ID (combinational)
operand1  out  WIDTH  ALU operand1 (forwarded rs)
operand2  out  WIDTH  ALU operand2 (immediate or forwarded rt)
store_data  out  WIDTH  forwarded rt, for sw
ALUop  out  3  registered ALU operation code
shamt  out  5  registered shift amount
e_dest  out  RADDR  destination: rd if regdst, else rt
e_regwrite, e_memread, e_memwrite, e_memtoreg, e_branch  out  1 each  registered controls

Behaviour:
- Reset (async, reset=1): every registered field clears to 0, i.e. a bubble (add, regwrite=0, memread=0, memwrite=0, branch=0).
  - Resulting outputs: ALUop=000, shamt=0, e_dest=0, all e_* controls=0.
  - operand1/operand2/store_data are then combinational on the cleared fields, so they read 0 unless a forwarding match on register 0 would apply, which is prohibited.
- Hazard: hazard = e_memread & (e_dest!=0) & (e_dest==d_rs | e_dest==d_rt).
  - stall = hazard & ~flush.
- Update priority at posedge clk: flush > hazard > load.
  - flush: the register loads a bubble.
  - hazard: the register loads a bubble; upstream holds, so the same decode is re-presented next cycle.
  - Otherwise: all d_* fields are captured.
  - Stage latency is 1 cycle.
- Forwarding (combinational on the registered rs/rt), for each source register r:
  - xm_regwrite & xm_rd!=0 & xm_rd==r → xm_result.
  - Else mw_regwrite & mw_rd!=0 & mw_rd==r → mw_result.
  - Else the registered register-file value.
  - EX/MEM strictly beats MEM/WB when both match.
  - Register 0 is never forwarded.
- operand2 = registered imm when alusrc=1; else forwarded rt. store_data is always forwarded rt.
- A load-use stall lasts exactly one cycle. The next cycle, the load is in EX/MEM with memread gone from this stage, and the value is then forwarded from MEM/WB.
- If reset asserts mid-stall, the bubble state is entered immediately and stall deasserts.

Optional Feature:
- Macro: HAZARD_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each increments once per clk in which stall / flush is 1.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - ALUop constants: ALU_ADD=000, ALU_SUB=001, ALU_SLL=010, ALU_SRL=011, ALU_OR=100, ALU_AND=101, ALU_SLT=110, ALU_BNE=111.
  - WIDTH/RADDR defaults.
- Sub-module forward_unit (purely combinational) takes a register address plus the EX/MEM and MEM/WB ports, and returns the selected value. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset during active traffic → all e_* = 0, ALUop=000, stall=0 on the same cycle, without waiting for a clock edge.
- Forwarding from EX/MEM: registered rs=5, xm_regwrite=1, xm_rd=5, xm_result=32'h1234 → operand1=32'h1234.
- Forwarding priority: registered rt=5 with both xm_rd=5 and mw_rd=5 (values 0x1111 and 0x2222), alusrc=0 → operand2=0x1111 and store_data=0x1111.
- Register zero: registered rs=0, xm_regwrite=1, xm_rd=0, xm_result=0xFFFF → operand1 = registered rs_data (0).
- Load-use: lw with e_dest=8 in the stage and decode d_rt=8 → stall=1 for one cycle, the next e_regwrite=0 (bubble), then the instruction issues with mw forwarding.
- flush=1 together with a hazard → stall=0, the next stage state is a bubble.
- With HAZARD_CNT_EN: three stall cycles → stall_cnt=3.
